// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle Moore sequencer for the CPU datapath (regfile,
// A/B/C registers, ALU, status register). A start pulse in WAIT captures the
// decoded opcode/op fields; the FSM then steps through the register reads,
// the ALU load and the regfile write-back for MOV-imm, MOV-reg, ADD, CMP,
// AND and MVN.
//
// Build option: define FSM_ILLEGAL_TRAP_EN to trap unsupported instructions
// in a HALT state (illegal = 1, w = 0) that only reset can leave. Without it,
// unsupported instructions return silently to WAIT and illegal is tied 0.
module datapath_ctrl #(
  parameter logic [1:0] VSEL_C   = 2'b00,
  parameter logic [1:0] VSEL_IMM = 2'b01
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic       write,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       illegal
);

  localparam logic [2:0] OPC_MOV    = 3'b110;
  localparam logic [2:0] OPC_ALU    = 3'b101;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;

  // One-hot register-field selects presented to the instruction decoder.
  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
`ifdef FSM_ILLEGAL_TRAP_EN
    ,S_HALT     = 3'd7
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [1:0] op_q, op_d;

  logic is_mov_imm;
  logic is_mov_reg;
  logic is_alu;
  logic is_cmp;

  // Classify the captured instruction; the live opcode/op inputs are never
  // consulted after the start edge.
  always_comb begin
    is_mov_imm = (opcode_q == OPC_MOV) && (op_q == OP_MOV_IMM);
    is_mov_reg = (opcode_q == OPC_MOV) && (op_q == OP_MOV_REG);
    is_alu     = (opcode_q == OPC_ALU);
    is_cmp     = is_alu && (op_q == OP_CMP);
  end

  // State and captured instruction fields; reset abandons any instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_WAIT;
      opcode_q <= 3'b000;
      op_q     <= 2'b00;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      op_q     <= op_d;
    end
  end

  // Next-state logic; opcode/op are captured only on the edge leaving WAIT.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;
    case (state_q)
      S_WAIT: begin
        if (s) begin
          state_d  = S_DECODE;
          opcode_d = opcode;
          op_d     = op;
        end
      end
      S_DECODE: begin
        if (is_mov_imm) begin
          state_d = S_WRITE_IMM;
        end else if (is_mov_reg) begin
          state_d = S_GET_B;
        end else if (is_alu) begin
          state_d = S_GET_A;
        end else begin
`ifdef FSM_ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_WRITE_IMM: state_d = S_WAIT;
      S_GET_A:     state_d = S_GET_B;
      S_GET_B:     state_d = S_ALU;
      S_ALU:       state_d = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_d = S_WAIT;
`ifdef FSM_ILLEGAL_TRAP_EN
      S_HALT:      state_d = S_HALT;
`endif
      default:     state_d = S_WAIT;
    endcase
  end

  // Moore output decode: strobes depend only on the state and captured fields.
  always_comb begin
    w       = 1'b0;
    nsel    = NSEL_NONE;
    write   = 1'b0;
    loada   = 1'b0;
    loadb   = 1'b0;
    loadc   = 1'b0;
    loads   = 1'b0;
    asel    = 1'b0;
    bsel    = 1'b0;
    vsel    = VSEL_C;
    illegal = 1'b0;
    case (state_q)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        // MOV-reg reuses the ADD path with A forced to zero, so C = Rm.
        loadc = 1'b1;
        asel  = is_mov_reg;
        loads = is_cmp;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
`ifdef FSM_ILLEGAL_TRAP_EN
      S_HALT: illegal = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
